// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage SRAM controller: FSM encoding,
// default address base and SRAM geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned ADDR_BASE_DEF   = 1024;
  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam int unsigned SRAM_DATA_W     = 16;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  // Byte offset into data memory; wraps at 32 bits like the CPU adder.
  function automatic logic [31:0] data_offset(input logic [31:0] adr,
                                              input logic [31:0] base);
    return adr - base;
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state timer for one 16-bit SRAM half-access: loads WAIT_CYCLES-1 on
// phase entry and counts down to a terminal count of zero.
module sram_phase_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_cycle
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last_cycle = (count == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting each 32-bit load/store into two timed
// 16-bit accesses on an asynchronous SRAM; ready low freezes the pipeline.
//
// state   | meaning
// IDLE    | no access; ready follows ~(memRead|memWrite), request latched here
// LO      | low half-word access, WAIT_CYCLES cycles
// HI      | high half-word access, WAIT_CYCLES cycles
// DONE    | one cycle, ready high, readData holds the full word
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [31:0]            memAdr,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t state, state_nxt;

  logic                   op_write;
  logic [SRAM_ADDR_W-2:0] word_idx;
  logic [31:0]            wdata;
  logic [31:0]            data_adr;
  logic                   req;
  logic                   accept;
  logic                   phase_load;
  logic                   last_cycle;
  logic                   half_sel;
  logic                   unused_adr_bits;

  assign data_adr        = data_offset(memAdr, 32'(ADDR_BASE));
  assign req             = memRead | memWrite;
  assign unused_adr_bits = ^{data_adr[31:SRAM_ADDR_W+1], data_adr[1:0]};

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (phase_load),
    .last_cycle (last_cycle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    phase_load  = 1'b0;
    ready       = 1'b0;
    half_sel    = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state)
      ST_IDLE: begin
        ready = ~req;
        if (req) begin
          accept     = 1'b1;
          phase_load = 1'b1;
          state_nxt  = ST_LO;
        end
      end
      ST_LO: begin
        if (last_cycle) begin
          phase_load = 1'b1;
          state_nxt  = ST_HI;
        end
      end
      ST_HI: begin
        half_sel = 1'b1;
        if (last_cycle) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        ready     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (state == ST_LO || state == ST_HI) begin
      sram_addr = {word_idx, half_sel};
      if (op_write) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = half_sel ? wdata[31:16] : wdata[15:0];
        // Final wait cycle is a hold cycle with WE released, unless there is only one.
        sram_we_n   = last_cycle && (WAIT_CYCLES != 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_write <= 1'b0;
      word_idx <= '0;
      wdata    <= '0;
      readData <= '0;
    end else begin
      if (accept) begin
        op_write <= memWrite;
        word_idx <= data_adr[SRAM_ADDR_W:2];
        wdata    <= writeData;
      end
      if (!op_write && last_cycle) begin
        if (state == ST_LO) begin
          readData[15:0] <= sram_dq_in;
        end
        if (state == ST_HI) begin
          readData[31:16] <= sram_dq_in;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory-stage controller between the EXE/MEM pipeline register and an external 16-bit asynchronous SRAM. It replaces the single-cycle data memory with a multi-cycle one. Each 32-bit load/store becomes two 16-bit SRAM accesses with programmable wait states. While the access is in progress it deasserts ready, and the hazard/freeze logic stalls the pipeline on ~ready.

Parameters:
ADDR_BASE, 1024, byte address of data-memory word 0; subtracted from memAdr
SRAM_ADDR_W, 18, SRAM half-word address width
WAIT_CYCLES, 2, cycles each 16-bit half-access is held (legal >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
memRead  in  1  load request from MEM stage
memWrite  in  1  store request from MEM stage
memAdr  in  32  byte address
writeData  in  32  store data
readData  out  32  load result, registered
ready  out  1  high = no access pending; pipeline freeze = ~ready
sram_addr  out  SRAM_ADDR_W  SRAM half-word address
sram_dq_out  out  16  SRAM write data
sram_dq_in  in  16  SRAM read data
sram_dq_oe  out  1  high = controller drives DQ bus
sram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE, phase counter 0, readData 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1. ready is 1 after reset.
- Address mapping:
  - dataAdr = memAdr - ADDR_BASE, computed with 32-bit wrap.
  - word index = dataAdr[SRAM_ADDR_W:2]. Upper bits are dropped, so out-of-range addresses wrap.
  - Low half address = {index, 0}; high half address = {index, 1}.
- Request priority: memWrite has priority. If memRead and memWrite are both high, only the write is performed.
- State IDLE:
  - ready = ~(memRead | memWrite), combinational, so the freeze takes effect in the same cycle the request appears.
  - On a request, latch the operation, the word index and writeData. Move to LO.
- State LO, WAIT_CYCLES cycles:
  - sram_addr = low half address.
  - Write: sram_dq_oe = 1 and sram_dq_out = wdata[15:0]. sram_we_n = 0 in phase cycles 0..WAIT_CYCLES-2 and 1 in the last cycle (hold cycle). If WAIT_CYCLES = 1, sram_we_n = 0 for the single cycle.
  - Read: sram_dq_oe = 0 and sram_we_n = 1. On the last phase cycle, capture sram_dq_in into readData[15:0].
  - Then move to HI.
- State HI: identical to LO, using the high half address, wdata[31:16] and readData[31:16]. Then move to DONE.
- State DONE, 1 cycle:
  - ready = 1, and readData holds the full word.
  - memRead, memWrite, memAdr and writeData are ignored.
  - Next state is IDLE.
- Latency: request seen in cycle 0; LO in cycles 1..W; HI in cycles W+1..2W; DONE in cycle 2W+1. ready is low for 2W+1 cycles.
- Input stability: the pipeline holds its inputs stable while frozen. The controller relies only on the values latched in IDLE.
- readData retention: readData keeps its value until the next read updates it. Writes never change it. readData[15:0] updates before readData[31:16] during a read; only the value in DONE is architecturally valid.
- Back-to-back requests: IDLE re-evaluates the request the cycle after DONE. There is no idle gap requirement.
- Reset mid-operation: the next cycle is IDLE with reset values on all outputs. No further SRAM strobes are issued, and the partial write is not completed.
- Bus contention: sram_dq_oe is never 1 on a read phase or in IDLE/DONE.

Decomposition:
- Shared package (mem_pkg): state encoding IDLE/LO/HI/DONE, the ADDR_BASE default, and the SRAM width constants.
- One sub-module: sram_phase_counter. It is a down-counter loaded with WAIT_CYCLES-1 at phase entry and outputs last_cycle. The FSM and datapath stay in the top module.

Test Plan:
1. Assert rst for 2 cycles, then release -> ready=1, sram_we_n=1, sram_dq_oe=0, readData=0. No SRAM activity with no requests.
2. W=2; memWrite with memAdr=0x408, writeData=0xDEADBEEF:
   - Cycles 1-2: sram_addr=4, dq_out=0xBEEF.
   - Cycles 3-4: sram_addr=5, dq_out=0xDEAD.
   - sram_we_n low only in cycles 1 and 3.
   - ready low in cycles 0-4 and high in cycle 5.
3. memRead with memAdr=0x408 after test 2, against the SRAM model -> readData=0xDEADBEEF in cycle 5. readData is unchanged after a subsequent write to 0x40C.
4. memRead=memWrite=1, memAdr=0x400, writeData=0x12345678 -> write strobes to addresses 0 and 1. The model shows 0x5678/0x1234 and readData is unchanged.
5. rst asserted during HI of a write -> next cycle IDLE, sram_we_n=1, sram_dq_oe=0, ready=1. The model's high half is not written.
6. memAdr=0x400+(1<<19) writes to SRAM addresses 0/1 (wrap). A second request is held high through DONE -> it is re-accepted the cycle after DONE and serviced fully.
